// File: rtl/mv_run_sequencer_if.sv
// Command and Controller-side signal bundle for the matrix-vector run sequencer.
// The sequencer takes the slave view; the register block / Controller side takes
// the master view.
interface mv_run_sequencer_if;
  logic        start;
  logic        abort;
  logic [8:0]  cfg_width;
  logic [15:0] cfg_iteration;
  logic        finish;
  logic        ctrl_rstn;
  logic        running;
  logic [8:0]  width;
  logic [15:0] iteration;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic        irq;
  logic [31:0] cycle_count;

  modport slave (
    input  start, abort, cfg_width, cfg_iteration, finish,
    output ctrl_rstn, running, width, iteration, busy, done, status, irq, cycle_count
  );

  modport master (
    output start, abort, cfg_width, cfg_iteration, finish,
    input  ctrl_rstn, running, width, iteration, busy, done, status, irq, cycle_count
  );
endinterface

// File: rtl/mv_run_sequencer.sv
// Run sequencer in front of the matrix-vector Controller: validates and latches
// the command, holds the Controller in reset for a clear window, keeps running
// asserted until finish, and reports termination via status/irq/cycle_count.
module mv_run_sequencer #(
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned MAX_WIDTH  = 384,
  parameter logic [31:0] TIMEOUT    = 32'hFFFF_FFFF
) (
  input logic               clk,
  input logic               rst,
  mv_run_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_CLEAR = 3'd2,
    ST_RUN   = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  localparam logic [1:0]  STAT_OK      = 2'b00;
  localparam logic [1:0]  STAT_BAD     = 2'b01;
  localparam logic [1:0]  STAT_TIMEOUT = 2'b10;
  localparam logic [1:0]  STAT_ABORT   = 2'b11;
  // Clear/flush counter is loaded with the last index so the window is exactly CLR_CYCLES long.
  localparam logic [31:0] CLR_LAST     = 32'(CLR_CYCLES - 32'd1);
  localparam logic [8:0]  MAX_W        = 9'(MAX_WIDTH);

  state_t      state_r;
  logic [31:0] clr_cnt_r;
  logic [1:0]  pending_r;
  logic        ctrl_rstn_r;
  logic        running_r;
  logic [8:0]  width_r;
  logic [15:0] iteration_r;
  logic        busy_r;
  logic        done_r;
  logic [1:0]  status_r;
  logic        irq_r;
  logic [31:0] cycle_count_r;
  logic        cfg_ok_s;
  logic [31:0] cycle_inc_s;

  // Config legality on the latched values (evaluated while in CHECK).
  always_comb begin
    cfg_ok_s = 1'b0;
    if ((width_r != 9'd0) && ((width_r % 9'd6) == 9'd0) &&
        (width_r <= MAX_W) && (iteration_r != 16'd0)) begin
      cfg_ok_s = 1'b1;
    end else begin
      cfg_ok_s = 1'b0;
    end
  end

  // Saturating next value of the run-cycle counter.
  always_comb begin
    cycle_inc_s = cycle_count_r;
    if (cycle_count_r != 32'hFFFF_FFFF) begin
      cycle_inc_s = cycle_count_r + 32'd1;
    end else begin
      cycle_inc_s = cycle_count_r;
    end
  end

  // Sequencer FSM; every output is registered and updated on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      clr_cnt_r     <= 32'd0;
      pending_r     <= STAT_OK;
      ctrl_rstn_r   <= 1'b0;
      running_r     <= 1'b0;
      width_r       <= 9'd6;
      iteration_r   <= 16'd1;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      status_r      <= STAT_OK;
      irq_r         <= 1'b0;
      cycle_count_r <= 32'd0;
    end else begin
      irq_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ctrl_rstn_r <= 1'b1;
          running_r   <= 1'b0;
          if (bus.start) begin
            width_r       <= bus.cfg_width;
            iteration_r   <= bus.cfg_iteration;
            done_r        <= 1'b0;
            status_r      <= STAT_OK;
            cycle_count_r <= 32'd0;
            busy_r        <= 1'b1;
            state_r       <= ST_CHECK;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (bus.abort) begin
            pending_r   <= STAT_ABORT;
            clr_cnt_r   <= CLR_LAST;
            ctrl_rstn_r <= 1'b0;
            state_r     <= ST_FLUSH;
          end else if (cfg_ok_s) begin
            clr_cnt_r   <= CLR_LAST;
            ctrl_rstn_r <= 1'b0;
            state_r     <= ST_CLEAR;
          end else begin
            status_r <= STAT_BAD;
            irq_r    <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          if (bus.abort) begin
            pending_r <= STAT_ABORT;
            clr_cnt_r <= CLR_LAST;
            state_r   <= ST_FLUSH;
          end else if (clr_cnt_r == 32'd0) begin
            ctrl_rstn_r   <= 1'b1;
            running_r     <= 1'b1;
            cycle_count_r <= 32'd1;
            state_r       <= ST_RUN;
          end else begin
            clr_cnt_r <= clr_cnt_r - 32'd1;
          end
        end
        ST_RUN: begin
          // finish beats abort, abort beats timeout.
          if (bus.finish) begin
            running_r <= 1'b0;
            done_r    <= 1'b1;
            status_r  <= STAT_OK;
            irq_r     <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end else if (bus.abort || (cycle_count_r == TIMEOUT)) begin
            pending_r   <= bus.abort ? STAT_ABORT : STAT_TIMEOUT;
            clr_cnt_r   <= CLR_LAST;
            running_r   <= 1'b0;
            ctrl_rstn_r <= 1'b0;
            state_r     <= ST_FLUSH;
          end else begin
            cycle_count_r <= cycle_inc_s;
          end
        end
        ST_FLUSH: begin
          if (clr_cnt_r == 32'd0) begin
            ctrl_rstn_r <= 1'b1;
            status_r    <= pending_r;
            irq_r       <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            clr_cnt_r <= clr_cnt_r - 32'd1;
          end
        end
        default: begin
          ctrl_rstn_r <= 1'b1;
          running_r   <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ctrl_rstn   = ctrl_rstn_r;
  assign bus.running     = running_r;
  assign bus.width       = width_r;
  assign bus.iteration   = iteration_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.status      = status_r;
  assign bus.irq         = irq_r;
  assign bus.cycle_count = cycle_count_r;

endmodule

// File: doc/mv_run_sequencer.md
Name: mv_run_sequencer

Overview:
Command/sequencing stage directly upstream of the matrix-vector Controller. It accepts a start command from the register interface, validates and latches width/iteration, flushes the Controller pipeline, and holds running until the Controller pulses finish. It then drops running and reports completion, abort, timeout or bad-config through status, an irq pulse and a run-cycle counter.

Parameters:
CLR_CYCLES, 2, cycles ctrl_rstn is held low before each run and after each abort/timeout (>=1)
MAX_WIDTH, 384, largest accepted width (0x180)
TIMEOUT, 32'hFFFF_FFFF, RUN cycles allowed before a timeout abort

Ports:
clk  in  1  system clock, all logic posedge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle command pulse; only honoured in IDLE
abort  in  1  one-cycle abort request
cfg_width  in  9  requested submatrix width
cfg_iteration  in  16  requested iteration count
finish  in  1  completion pulse from Controller
ctrl_rstn  out  1  active-low reset to Controller
running  out  1  run enable to Controller
width  out  9  latched width to Controller
iteration  out  16  latched iteration to Controller
busy  out  1  high in every state except IDLE
done  out  1  sticky; last run completed normally
status  out  2  00 ok, 01 bad config, 10 timeout, 11 aborted
irq  out  1  one-cycle pulse on every command termination
cycle_count  out  32  RUN cycles of the current or last run

Behaviour:
- Reset values (while rst is high): state IDLE, ctrl_rstn=0, running=0, width=6, iteration=1, busy=0, done=0, status=00, irq=0, cycle_count=0. rst mid-run aborts immediately; no irq is produced.
- Outside rst, ctrl_rstn=1 except in CLEAR and FLUSH.
- States: IDLE, CHECK, CLEAR, RUN, FLUSH.
- IDLE: start=1 at cycle t latches cfg_* into width/iteration, clears done, and moves to CHECK at t+1.
- CHECK (1 cycle): the config is valid iff width!=0, width%6==0, width<=MAX_WIDTH and iteration!=0.
  - Invalid: go to IDLE; at t+2 status=01 and irq=1.
  - Valid: go to CLEAR at t+2.
- CLEAR: ctrl_rstn=0 for exactly CLR_CYCLES cycles; running=0. Then RUN at t+2+CLR_CYCLES.
- RUN: running=1. cycle_count is loaded with 1 on the first RUN cycle and increments by 1 per RUN cycle, saturating at all-ones.
- finish=1 in RUN: the next cycle is IDLE with running=0, done=1, status=00 and irq=1. running therefore falls exactly 1 cycle after finish, as the Controller requires to release its stop-feeding latch.
- Timeout: when cycle_count==TIMEOUT in RUN without finish, go to FLUSH with status pending 10.
- abort=1 in CHECK, CLEAR or RUN: go to FLUSH with status pending 11.
- FLUSH: running=0 and ctrl_rstn=0 for CLR_CYCLES cycles. Then IDLE with status set to the pending code and irq=1. done stays 0.
- Priorities and ignored inputs:
  - finish beats abort and timeout in the same cycle.
  - abort beats timeout.
  - abort in IDLE or FLUSH is ignored.
  - start while busy is ignored, with no side effects.
  - finish outside RUN is ignored.
- width/iteration hold constant from latch until the next accepted start; the Controller never sees them change while running=1.
- status and cycle_count hold until the next accepted start. An accepted start resets status to 00; cycle_count resets to 0 when CHECK is entered.
- irq is never high for more than 1 cycle. Back-to-back commands: a start in the first IDLE cycle after termination is accepted.

Test Plan:
- Normal run: CLR_CYCLES=2, start with width=12, iteration=3 at t=0; finish pulsed at t=40. Required: CHECK at t=1; ctrl_rstn=0 at t=2..3; running=1 at t=4..40; running=0, done=1, irq=1, status=00 and cycle_count=37 at t=41.
- Bad config: separate starts with width=13, width=0, width=390 and iteration=0. Required for each: irq at t+2, status=01, running never 1, ctrl_rstn never 0.
- Abort in RUN at cycle 10 of RUN. Required: running=0 next cycle; ctrl_rstn=0 for 2 cycles; then irq with status=11, done=0, cycle_count=10.
- Timeout: TIMEOUT=20, finish never pulsed. Required: 20 RUN cycles, then FLUSH, then status=10 with irq; cycle_count=20.
- Contention:
  - finish and abort in the same cycle: status=00 and done=1.
  - start during RUN: ignored, width unchanged.
  - finish in IDLE: no irq.
- Reset mid-run: rst=1 at RUN cycle 5. Required: next cycle running=0, ctrl_rstn=0, all outputs at reset values, no irq. After rst falls, a fresh start completes normally.
